fb_sdram_arbiter: RTL and testbench

Single-clock scheduler that shares one Avalon-MM SDRAM controller port between the camera write stream (MIPI pixels into frame memory) and the framebuffer read stream (frame memory out to video). It buffers each stream in an internal FIFO, issues fixed-length bursts of single-word Avalon transfers, and tags frame starts so that both streams stay frame-aligned. It sits between the MIPI/framebuffer stream adapters and the SDRAM controller inside the video subsystem.

---
 rtl/fb_sdram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fb_sdram_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sdram_arbiter.sv
// fb_sdram_arbiter: shares one Avalon-MM SDRAM port between the camera write
// stream and the framebuffer read stream. Each stream is buffered in a FIFO
// and fixed BURST_LEN bursts of single-word transfers are scheduled.
// Optional feature macro: FB_ARB_DOUBLE_BUF_EN (ping-pong frame buffers).
// Ports:
//   clk_clk, reset_reset_n      clock, synchronous active-low reset
//   wr_data/wr_dv/wr_start      pixel input (no backpressure)
//   wr_overflow                 sticky drop flag
//   rd_data/rd_dv/rd_start      show-ahead pixel output, rd_rdy accepts
//   avm_*                       Avalon-MM master to SDRAM controller
module fb_sdram_arbiter #(
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned FRAME_WORDS  = 76800,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [14:0]       wr_data,
  input  logic              wr_dv,
  input  logic              wr_start,
  output logic              wr_overflow,
  output logic [14:0]       rd_data,
  output logic              rd_dv,
  output logic              rd_start,
  input  logic              rd_rdy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FW_LAST = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t            state, state_n;
  logic [15:0]       wmem [FIFO_DEPTH];
  logic [15:0]       rmem [FIFO_DEPTH];
  logic [AW-1:0]     wwp, wrp, rwp, rrp;
  logic [LW-1:0]     wlvl, rlvl, outstanding, beat;
  logic [LW:0]       rd_sum;
  logic [SW-1:0]     starve;
  logic [ADDR_W-1:0] wr_off, rd_off, ret_off, w_off_n, rd_off_n, w_addr, r_addr;
  logic [15:0]       w_src, r_head;
  logic              wr_acc, rd_acc, wpush, wpop, wfull, rpush, rpop, rfull, ret_ok;
  logic              wr_elig, rd_elig, last_beat, wr_load, rd_load;
  logic              unused_rdata_msb;
`ifdef FB_ARB_DOUBLE_BUF_EN
  localparam logic [ADDR_W-1:0] FW = ADDR_W'(FRAME_WORDS);
  logic              wr_buf, rd_buf, w_buf_n;
`endif

  assign unused_rdata_msb = avm_readdata[15];

  assign wr_acc    = avm_write & ~avm_waitrequest;
  assign rd_acc    = avm_read & ~avm_waitrequest;
  assign wpop      = wr_acc;
  assign wfull     = (wlvl == LW'(FIFO_DEPTH));
  assign wpush     = wr_dv & (~wfull | wpop);
  assign rpop      = rd_dv & rd_rdy;
  assign rfull     = (rlvl == LW'(FIFO_DEPTH));
  assign ret_ok    = avm_readdatavalid & (outstanding != '0);
  assign rpush     = ret_ok & (~rfull | rpop);
  assign wr_elig   = (wlvl >= LW'(BURST_LEN));
  assign rd_sum    = {1'b0, rlvl} + {1'b0, outstanding};
  assign rd_elig   = (rd_sum <= (LW+1)'(FIFO_DEPTH - BURST_LEN));
  assign last_beat = (beat == LW'(BURST_LEN - 1));

  // The write command register is reloaded on the same edge that pops the
  // current head, so mid-burst the next word is the entry behind the head.
  assign w_src    = (state == WR_BURST) ? wmem[wrp + AW'(1)] : wmem[wrp];
  assign w_off_n  = w_src[15] ? '0 : ((wr_off == FW_LAST) ? '0 : wr_off + ADDR_W'(1));
  assign rd_off_n = (rd_off == FW_LAST) ? '0 : rd_off + ADDR_W'(1);
`ifdef FB_ARB_DOUBLE_BUF_EN
  assign w_buf_n  = wr_buf ^ w_src[15];
  assign w_addr   = BASE + (w_buf_n ? FW : '0) + w_off_n;
  assign r_addr   = BASE + (rd_buf ? FW : '0) + rd_off;
`else
  assign w_addr   = BASE + w_off_n;
  assign r_addr   = BASE + rd_off;
`endif

  assign r_head   = rmem[rrp];
  assign rd_dv    = (rlvl != '0);
  assign rd_data  = rd_dv ? r_head[14:0] : '0;
  assign rd_start = rd_dv & r_head[15];

  always_comb begin
    state_n = state;
    wr_load = 1'b0;
    rd_load = 1'b0;
    case (state)
      IDLE: begin
        if (rd_elig && (!wr_elig || (starve < SW'(STARVE_LIMIT)))) begin
          state_n = RD_BURST;
          rd_load = 1'b1;
        end else if (wr_elig) begin
          state_n = WR_BURST;
          wr_load = 1'b1;
        end
      end
      WR_BURST: if (wr_acc) begin
        if (last_beat) state_n = IDLE;
        else           wr_load = 1'b1;
      end
      RD_BURST: if (rd_acc) begin
        if (last_beat) state_n = IDLE;
        else           rd_load = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (wpush) wmem[wwp] <= {wr_start, wr_data};
    if (rpush) rmem[rwp] <= {(ret_off == '0), avm_readdata[14:0]};
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state         <= IDLE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      avm_address   <= BASE;
      wr_overflow   <= 1'b0;
      wwp           <= '0;
      wrp           <= '0;
      rwp           <= '0;
      rrp           <= '0;
      wlvl          <= '0;
      rlvl          <= '0;
      outstanding   <= '0;
      beat          <= '0;
      starve        <= '0;
      wr_off        <= '0;
      rd_off        <= '0;
      ret_off       <= '0;
`ifdef FB_ARB_DOUBLE_BUF_EN
      wr_buf        <= 1'b0;
      rd_buf        <= 1'b0;
`endif
    end else begin
      state <= state_n;

      if (wpush) wwp <= wwp + AW'(1);
      if (wpop)  wrp <= wrp + AW'(1);
      wlvl <= wlvl + LW'(wpush) - LW'(wpop);
      if (wr_dv && wfull && !wpop) wr_overflow <= 1'b1;

      if (rpush) rwp <= rwp + AW'(1);
      if (rpop)  rrp <= rrp + AW'(1);
      rlvl <= rlvl + LW'(rpush) - LW'(rpop);

      outstanding <= outstanding + LW'(rd_acc) - LW'(ret_ok);
      if (ret_ok) ret_off <= (ret_off == FW_LAST) ? '0 : ret_off + ADDR_W'(1);

      if (state == IDLE)        beat <= '0;
      else if (wr_acc | rd_acc) beat <= beat + LW'(1);

      if (state == IDLE && state_n == RD_BURST && wr_elig && starve < SW'(STARVE_LIMIT))
        starve <= starve + SW'(1);
      else if (state == IDLE && state_n == WR_BURST)
        starve <= '0;

      if (wr_load) begin
        avm_write     <= 1'b1;
        avm_writedata <= {1'b0, w_src[14:0]};
        avm_address   <= w_addr;
        wr_off        <= w_off_n;
`ifdef FB_ARB_DOUBLE_BUF_EN
        wr_buf        <= w_buf_n;
`endif
      end else if (wr_acc) begin
        avm_write <= 1'b0;
      end

      if (rd_load) begin
        avm_read    <= 1'b1;
        avm_address <= r_addr;
        rd_off      <= rd_off_n;
`ifdef FB_ARB_DOUBLE_BUF_EN
        if (rd_off == FW_LAST) rd_buf <= ~wr_buf;
`endif
      end else if (rd_acc) begin
        avm_read <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Scoreboard bench for fb_sdram_arbiter with FRAME_WORDS=16. Stimulus pushes
// expected writes/reads into queues; a bus loop (forked) pops and compares on
// every accepted Avalon write and every rd_dv&rd_rdy transfer, and models a
// latency-2 SDRAM returning readdata = address.
module tb_fb_sdram_arbiter;

  localparam int unsigned FW = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [14:0] wr_data;
  logic        wr_dv, wr_start, wr_overflow;
  logic [14:0] rd_data;
  logic        rd_dv, rd_start, rd_rdy;
  logic [21:0] avm_address;
  logic        avm_read, avm_write;
  logic [15:0] avm_writedata, avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;

  fb_sdram_arbiter #(.FRAME_WORDS(FW)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .wr_data(wr_data), .wr_dv(wr_dv), .wr_start(wr_start), .wr_overflow(wr_overflow),
    .rd_data(rd_data), .rd_dv(rd_dv), .rd_start(rd_start), .rd_rdy(rd_rdy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  initial forever #5 clk_clk = ~clk_clk;

  int unsigned vectors = 0, miscompares = 0;
  logic [37:0] wq[$];
  logic [15:0] rq[$];
  logic [7:0]  order_exp[$], order_got[$];
  int unsigned push_cyc[$];
  bit          log_bursts = 0;
  int unsigned cyc = 0, wr_seen = 0, rd_beats = 0, rd_taken = 0, max_buf = 0;
  int unsigned wr_model_off = 0;
  bit          s1_v = 0, s2_v = 0;
  logic [15:0] s1_d = '0, s2_d = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic push_px(input bit tag, input logic [14:0] px, input bit drop);
    wr_dv = 1'b1;
    wr_start = tag;
    wr_data = px;
    if (!drop) begin
      wr_model_off = tag ? 0 : ((wr_model_off == FW-1) ? 0 : wr_model_off + 1);
      wq.push_back({22'(wr_model_off), 1'b0, px});
    end
    tick();
    if (!drop) push_cyc.push_back(cyc);
    wr_dv = 1'b0;
    wr_start = 1'b0;
  endtask

  task automatic wait_wq(input string name, input int unsigned limit);
    int unsigned n = 0;
    while (wq.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk(name, wq.size(), 0);
  endtask

  task automatic bus_loop();
    logic [37:0] we;
    logic [15:0] re;
    int unsigned need;
    forever begin
      @(negedge clk_clk);
      cyc++;
      if (avm_write && !avm_waitrequest) begin
        if (log_bursts && wr_seen % 8 == 0) order_got.push_back(8'h57);
        if (wq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL wr_unexpected: write to 0x%0h with no pending expectation", avm_address);
        end else begin
          we = wq.pop_front();
          chk("wr_addr", avm_address, we[37:16]);
          chk("wr_data", avm_writedata, we[15:0]);
        end
        need = 8 * (wr_seen / 8 + 1);
        chk("wr_burst_gate", (push_cyc.size() >= need) && (push_cyc[need-1] + 2 <= cyc), 1);
        wr_seen++;
      end
      if (avm_read && !avm_waitrequest) begin
        if (log_bursts && rd_beats % 8 == 0) order_got.push_back(8'h52);
        rd_beats++;
      end
      avm_readdatavalid = s2_v;
      avm_readdata = s2_d;
      s2_v = s1_v;
      s2_d = s1_d;
      s1_v = avm_read && !avm_waitrequest;
      s1_d = avm_address[15:0];
      if (rd_dv && rd_rdy) begin
        if (rq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: word 0x%0h with no pending expectation", rd_data);
        end else begin
          re = rq.pop_front();
          chk("rd_data", rd_data, re[14:0]);
          chk("rd_start", rd_start, re[15]);
        end
        rd_taken++;
      end
      if (rd_beats - rd_taken > max_buf) max_buf = rd_beats - rd_taken;
    end
  endtask

  initial begin
    int unsigned n;
    reset_reset_n = 1'b0;
    wr_dv = 1'b0;
    wr_start = 1'b0;
    wr_data = '0;
    rd_rdy = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    for (int i = 0; i < 400; i++) rq.push_back({1'(i % FW == 0), 15'(i % FW)});
    order_exp.push_back(8'h57);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) order_exp.push_back(8'h52);
      order_exp.push_back(8'h57);
    end
    fork
      bus_loop();
    join_none

    // reset state
    repeat (3) tick();
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_rd_dv", rd_dv, 0);
    chk("rst_rd_start", rd_start, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_overflow", wr_overflow, 0);
    reset_reset_n = 1'b1;

    // reads fill the read FIFO with rd_rdy=0, then stop
    repeat (150) tick();
    chk("fill_rd_dv", rd_dv, 1);
    chk("fill_rd_start", rd_start, 1);
    chk("fill_rd_data", rd_data, 0);
    chk("fill_no_read", avm_read, 0);
    chk("fill_depth", rd_beats, 64);

    // one tagged frame of 16 pixels -> two write bursts to 0..15
    for (int i = 0; i < 16; i++) push_px(i == 0, 15'(16'h100 + i), 0);
    wait_wq("frame_drain", 200);

    // tag mid-burst, waitrequest stall on the 5th word (offset 1, 0x204)
    for (int i = 0; i < 8; i++) push_px(i == 3, 15'(16'h200 + i), 0);
    n = 0;
    while (wr_seen < 20 && n < 50) begin
      tick();
      n++;
    end
    chk("stall_reach", wr_seen, 20);
    avm_waitrequest = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_clk);
      chk("stall_write", avm_write, 1);
      chk("stall_addr", avm_address, 1);
      chk("stall_data", avm_writedata, 16'h0204);
      tick();
    end
    avm_waitrequest = 1'b0;
    wait_wq("stall_drain", 100);

    // overflow: 65 pushes while the bus is stalled
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 64; i++) push_px(0, 15'(16'h300 + i), 0);
    chk("ovf_after_64", wr_overflow, 0);
    push_px(0, 15'h340, 1);
    chk("ovf_after_65", wr_overflow, 1);
    repeat (3) tick();
    avm_waitrequest = 1'b0;
    wait_wq("ovf_drain", 400);
    chk("ovf_sticky", wr_overflow, 1);

    // arbitration with both streams eligible
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 40; i++) push_px(0, 15'(16'h400 + i), 0);
    log_bursts = 1'b1;
    avm_waitrequest = 1'b0;
    rd_rdy = 1'b1;
    n = 0;
    while (order_got.size() < 21 && n < 1000) begin
      tick();
      n++;
    end
    rd_rdy = 1'b0;
    log_bursts = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (i < order_got.size()) chk("burst_order", order_got[i], order_exp[i]);
      else chk("burst_order_missing", order_got.size(), 21);
    end
    wait_wq("arb_drain", 200);
    chk("rd_words_consumed", rd_taken > 150, 1);
    chk("max_buffered", max_buf <= 64, 1);

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
